// File: rtl/fp32_mul_round.sv
`timescale 1ns/1ps
// fp32_mul_round
// Back end of the single-precision multiply datapath. Accepts the raw
// mantissa product from the 24x24 multiplier together with the operand
// exponents, signs and classes, then normalises, rounds to nearest-even,
// handles overflow/underflow and special operands, and packs a binary32
// result. Two register stages with a valid/ready handshake on each side.
//
// Stage 1 (normalise): picks the fraction, guard and sticky bits from the
//   product, forms the unbiased-sum exponent and classifies special cases.
// Stage 2 (round/pack): applies round-to-nearest-even, checks the exponent
//   range and packs the result and the {invalid, overflow, underflow,
//   inexact} flags.
//
// Denormal results are flushed to signed zero; denormal inputs arrive
// already classed as zero by the upstream stage.

module fp32_mul_round #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int BIAS   = 127
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [2*(FRAC_W+1)-1:0]      in_prod,
  input  logic [EXP_W-1:0]             in_exp_a,
  input  logic [EXP_W-1:0]             in_exp_b,
  input  logic                         in_sign_a,
  input  logic                         in_sign_b,
  input  logic [1:0]                   in_cls_a,
  input  logic [1:0]                   in_cls_b,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [EXP_W+FRAC_W:0]        out_result,
  output logic [3:0]                   out_flags
);

  // Product width and the signed working exponent width. Two extra bits
  // cover the full range of exp_a + exp_b - BIAS (+1 for normalisation).
  localparam int PW = 2 * (FRAC_W + 1);
  localparam int EW = EXP_W + 2;
  localparam int RW = EXP_W + FRAC_W + 1;

  localparam logic signed [EW-1:0] C_BIAS = EW'(BIAS);
  localparam logic signed [EW-1:0] C_EMAX = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] C_ZERO = '0;

  localparam logic [1:0] CLS_NORM = 2'b00;
  localparam logic [1:0] CLS_ZERO = 2'b01;
  localparam logic [1:0] CLS_INF  = 2'b10;
  localparam logic [1:0] CLS_NAN  = 2'b11;

  // Canonical quiet NaN: positive, all-ones exponent, fraction MSB set.
  localparam logic [RW-1:0] C_QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

  // Special-case code carried from stage 1 to stage 2, in priority order.
  typedef enum logic [2:0] {
    SP_NONE    = 3'd0,
    SP_QNAN    = 3'd1,
    SP_INVALID = 3'd2,
    SP_INF     = 3'd3,
    SP_ZERO    = 3'd4
  } special_e;

  // Handshake
  logic w_adv1;
  logic w_adv2;

  // Stage 1 combinational
  logic                  w_msb;
  logic [FRAC_W-1:0]     w_frac;
  logic                  w_guard;
  logic                  w_sticky;
  logic signed [EW-1:0]  w_e_base;
  logic signed [EW-1:0]  w_e_norm;
  logic                  w_a_nan;
  logic                  w_b_nan;
  logic                  w_a_inf;
  logic                  w_b_inf;
  logic                  w_a_zero;
  logic                  w_b_zero;
  special_e              w_special;

  // Stage 1 registers
  logic                  r1_valid;
  logic                  r1_sign;
  logic signed [EW-1:0]  r1_e;
  logic [FRAC_W-1:0]     r1_frac;
  logic                  r1_guard;
  logic                  r1_sticky;
  special_e              r1_special;

  // Stage 2 combinational
  logic                  w_round_up;
  logic                  w_carry;
  logic [FRAC_W-1:0]     w_frac_rnd;
  logic signed [EW-1:0]  w_e_rnd;
  logic                  w_inexact;
  logic [RW-1:0]         w_result;
  logic [3:0]            w_flags;

  // Stage 2 registers
  logic                  r2_valid;
  logic [RW-1:0]         r2_result;
  logic [3:0]            r2_flags;

  // Pipeline advance: a stage moves when it is empty or its successor moves.
  always_comb begin
    w_adv2 = !r2_valid || out_ready;
    w_adv1 = !r1_valid || w_adv2;
  end

  assign in_ready   = w_adv1;
  assign out_valid  = r2_valid;
  assign out_result = r2_result;
  assign out_flags  = r2_flags;

  // Normalisation: the product of two [1,2) mantissas lies in [1,4), so the
  // leading one sits at bit PW-1 or PW-2; the former bumps the exponent.
  always_comb begin
    w_msb = in_prod[PW-1];
    if (w_msb) begin
      w_frac   = in_prod[PW-2 -: FRAC_W];
      w_guard  = in_prod[PW-2-FRAC_W];
      w_sticky = |in_prod[PW-3-FRAC_W:0];
    end else begin
      w_frac   = in_prod[PW-3 -: FRAC_W];
      w_guard  = in_prod[PW-3-FRAC_W];
      w_sticky = |in_prod[PW-4-FRAC_W:0];
    end
    w_e_base = $signed({2'b00, in_exp_a}) + $signed({2'b00, in_exp_b}) - C_BIAS;
    w_e_norm = w_e_base + $signed({{(EW-1){1'b0}}, w_msb});
  end

  // Operand classification into a single prioritised special-case code.
  always_comb begin
    w_a_nan  = (in_cls_a == CLS_NAN);
    w_b_nan  = (in_cls_b == CLS_NAN);
    w_a_inf  = (in_cls_a == CLS_INF);
    w_b_inf  = (in_cls_b == CLS_INF);
    w_a_zero = (in_cls_a == CLS_ZERO);
    w_b_zero = (in_cls_b == CLS_ZERO);
    w_special = SP_NONE;
    if (w_a_nan || w_b_nan) begin
      w_special = SP_QNAN;
    end else if ((w_a_inf && w_b_zero) || (w_a_zero && w_b_inf)) begin
      w_special = SP_INVALID;
    end else if (w_a_inf || w_b_inf) begin
      w_special = SP_INF;
    end else if (w_a_zero || w_b_zero) begin
      w_special = SP_ZERO;
    end else if ((in_cls_a == CLS_NORM) && (in_cls_b == CLS_NORM)) begin
      w_special = SP_NONE;
    end
  end

  // Stage 1 register: captures the normalised beat when the stage advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_valid   <= 1'b0;
      r1_sign    <= 1'b0;
      r1_e       <= '0;
      r1_frac    <= '0;
      r1_guard   <= 1'b0;
      r1_sticky  <= 1'b0;
      r1_special <= SP_NONE;
    end else if (w_adv1) begin
      r1_valid <= in_valid;
      if (in_valid) begin
        r1_sign    <= in_sign_a ^ in_sign_b;
        r1_e       <= w_e_norm;
        r1_frac    <= w_frac;
        r1_guard   <= w_guard;
        r1_sticky  <= w_sticky;
        r1_special <= w_special;
      end
    end
  end

  // Round to nearest-even; a fraction carry-out renormalises by bumping e.
  always_comb begin
    w_round_up             = r1_guard && (r1_sticky || r1_frac[0]);
    {w_carry, w_frac_rnd}  = {1'b0, r1_frac} + {{FRAC_W{1'b0}}, w_round_up};
    w_e_rnd                = r1_e + $signed({{(EW-1){1'b0}}, w_carry});
    w_inexact              = r1_guard || r1_sticky;
  end

  // Result packing. Underflow is judged on the pre-rounding exponent,
  // overflow on the post-rounding one; special operands override both.
  always_comb begin
    w_result = '0;
    w_flags  = 4'b0000;
    case (r1_special)
      SP_QNAN: begin
        w_result = C_QNAN;
      end
      SP_INVALID: begin
        w_result = C_QNAN;
        w_flags  = 4'b1000;
      end
      SP_INF: begin
        w_result = {r1_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      end
      SP_ZERO: begin
        w_result = {r1_sign, {(RW-1){1'b0}}};
      end
      default: begin
        if (r1_e <= C_ZERO) begin
          w_result = {r1_sign, {(RW-1){1'b0}}};
          w_flags  = 4'b0011;
        end else if (w_e_rnd >= C_EMAX) begin
          w_result = {r1_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          w_flags  = 4'b0101;
        end else begin
          w_result = {r1_sign, w_e_rnd[EXP_W-1:0], w_frac_rnd};
          w_flags  = {3'b000, w_inexact};
        end
      end
    endcase
  end

  // Stage 2 register: output holds while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r2_valid  <= 1'b0;
      r2_result <= '0;
      r2_flags  <= 4'b0000;
    end else if (w_adv2) begin
      r2_valid <= r1_valid;
      if (r1_valid) begin
        r2_result <= w_result;
        r2_flags  <= w_flags;
      end
    end
  end

endmodule

// File: tb/tb_fp32_mul_round.sv
`timescale 1ns/1ps
// Directed bench for fp32_mul_round: expected results are queued at
// acceptance and compared when the DUT hands a result to the consumer.
module tb_fp32_mul_round;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] in_prod;
  logic [7:0]  in_exp_a;
  logic [7:0]  in_exp_b;
  logic        in_sign_a;
  logic        in_sign_b;
  logic [1:0]  in_cls_a;
  logic [1:0]  in_cls_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags;

  int checks = 0;
  int errors = 0;
  logic [35:0] sb_q[$];
  logic [35:0] exp_e;
  int pops = 0;

  fp32_mul_round #(.EXP_W(8), .FRAC_W(23), .BIAS(127)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_prod    (in_prod),
    .in_exp_a   (in_exp_a),
    .in_exp_b   (in_exp_b),
    .in_sign_a  (in_sign_a),
    .in_sign_b  (in_sign_b),
    .in_cls_a   (in_cls_a),
    .in_cls_b   (in_cls_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic set_beat(input logic [47:0] prod, input logic [7:0] ea, input logic [7:0] eb,
                          input logic s_a, input logic s_b, input logic [1:0] ca, input logic [1:0] cb);
    in_valid  = 1'b1;
    in_prod   = prod;
    in_exp_a  = ea;
    in_exp_b  = eb;
    in_sign_a = s_a;
    in_sign_b = s_b;
    in_cls_a  = ca;
    in_cls_b  = cb;
  endtask

  // Present a beat and wait (bounded) for acceptance; queue its expectation.
  task automatic send(input logic [47:0] prod, input logic [7:0] ea, input logic [7:0] eb,
                      input logic s_a, input logic s_b, input logic [1:0] ca, input logic [1:0] cb,
                      input logic [31:0] er, input logic [3:0] ef);
    set_beat(prod, ea, eb, s_a, s_b, ca, cb);
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        sb_q.push_back({er, ef});
        #1;
        return;
      end
    end
    checks++;
    errors++;
    $error("FAIL accept_timeout observed=in_ready_low expected=accept");
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 30 && sb_q.size() != 0; n++) @(negedge clk);
    @(posedge clk);
    #1;
    chk("drain_empty", sb_q.size(), 32'd0);
  endtask

  // Scoreboard: compare each result on the cycle the consumer takes it.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_out observed=%h expected=none", out_result);
      end else begin
        exp_e = sb_q.pop_front();
        pops++;
        chk($sformatf("result#%0d", pops), out_result, exp_e[35:4]);
        chk($sformatf("flags#%0d", pops), {28'b0, out_flags}, {28'b0, exp_e[3:0]});
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_prod = '0; in_exp_a = '0; in_exp_b = '0;
    in_sign_a = 1'b0; in_sign_b = 1'b0; in_cls_a = 2'b00; in_cls_b = 2'b00;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_result", out_result, 32'h0);
    chk("rst_out_flags", {28'b0, out_flags}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Basic normalisation with exact two-cycle latency
    send(48'h900000000000, 8'd127, 8'd127, 1'b0, 1'b0, 2'b00, 2'b00, 32'h40100000, 4'b0000);
    idle();
    @(negedge clk);
    chk("lat_cycle1_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    chk("lat_cycle2_valid", {31'b0, out_valid}, 32'd1);
    drain();

    // Rounding: tie-odd up, tie-even hold, fraction carry-out
    send(48'h800001800000, 8'd127, 8'd127, 1'b0, 1'b0, 2'b00, 2'b00, 32'h40000002, 4'b0001);
    send(48'h800000800000, 8'd127, 8'd127, 1'b0, 1'b0, 2'b00, 2'b00, 32'h40000000, 4'b0001);
    send(48'hFFFFFF800000, 8'd127, 8'd127, 1'b0, 1'b0, 2'b00, 2'b00, 32'h40800000, 4'b0001);
    // Exponent range: overflow, underflow and the edges either side
    send(48'h400000000000, 8'd254, 8'd254, 1'b0, 1'b0, 2'b00, 2'b00, 32'h7F800000, 4'b0101);
    send(48'h400000000000, 8'd1,   8'd1,   1'b1, 1'b0, 2'b00, 2'b00, 32'h80000000, 4'b0011);
    send(48'h7FFFFF800000, 8'd254, 8'd127, 1'b0, 1'b0, 2'b00, 2'b00, 32'h7F7FFFFF, 4'b0000);
    send(48'h7FFFFFC00000, 8'd254, 8'd127, 1'b0, 1'b0, 2'b00, 2'b00, 32'h7F800000, 4'b0101);
    send(48'h400000000000, 8'd1,   8'd127, 1'b0, 1'b0, 2'b00, 2'b00, 32'h00800000, 4'b0000);
    send(48'h400000000000, 8'd0,   8'd127, 1'b0, 1'b0, 2'b00, 2'b00, 32'h00000000, 4'b0011);
    // Special operands (product is don't-care)
    send(48'h123456789ABC, 8'd200, 8'd3,   1'b0, 1'b0, 2'b10, 2'b01, 32'h7FC00000, 4'b1000);
    send(48'h123456789ABC, 8'd200, 8'd3,   1'b0, 1'b0, 2'b11, 2'b00, 32'h7FC00000, 4'b0000);
    send(48'hFFFFFFFFFFFF, 8'd200, 8'd3,   1'b0, 1'b1, 2'b10, 2'b00, 32'hFF800000, 4'b0000);
    send(48'hFFFFFFFFFFFF, 8'd9,   8'd250, 1'b1, 1'b1, 2'b01, 2'b10, 32'h7FC00000, 4'b1000);
    send(48'h800001800000, 8'd127, 8'd127, 1'b1, 1'b0, 2'b01, 2'b00, 32'h80000000, 4'b0000);
    send(48'h800001800000, 8'd127, 8'd127, 1'b1, 1'b0, 2'b00, 2'b11, 32'h7FC00000, 4'b0000);
    send(48'h800001800000, 8'd127, 8'd127, 1'b0, 1'b0, 2'b11, 2'b10, 32'h7FC00000, 4'b0000);
    idle();
    drain();

    // Backpressure: two beats fill the pipe, the third is held off
    out_ready = 1'b0;
    send(48'h900000000000, 8'd127, 8'd127, 1'b0, 1'b0, 2'b00, 2'b00, 32'h40100000, 4'b0000);
    send(48'h800001800000, 8'd127, 8'd127, 1'b0, 1'b0, 2'b00, 2'b00, 32'h40000002, 4'b0001);
    set_beat(48'h800000800000, 8'd127, 8'd127, 1'b0, 1'b0, 2'b00, 2'b00);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk($sformatf("bp_in_ready%0d", n), {31'b0, in_ready}, 32'd0);
      chk($sformatf("bp_out_valid%0d", n), {31'b0, out_valid}, 32'd1);
      chk($sformatf("bp_hold_result%0d", n), out_result, 32'h40100000);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
    send(48'h800000800000, 8'd127, 8'd127, 1'b0, 1'b0, 2'b00, 2'b00, 32'h40000000, 4'b0001);
    idle();
    @(negedge clk);
    chk("bp_flow_valid1", {31'b0, out_valid}, 32'd1);
    @(negedge clk);
    chk("bp_flow_valid2", {31'b0, out_valid}, 32'd1);
    drain();

    // Reset with two beats in flight discards them immediately
    send(48'h900000000000, 8'd127, 8'd127, 1'b0, 1'b0, 2'b00, 2'b00, 32'h40100000, 4'b0000);
    send(48'h800001800000, 8'd127, 8'd127, 1'b0, 1'b0, 2'b00, 2'b00, 32'h40000002, 4'b0001);
    idle();
    rst = 1'b1;
    sb_q.delete();
    #1;
    chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_out_result", out_result, 32'h0);
    chk("mid_rst_out_flags", {28'b0, out_flags}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    send(48'h800000800000, 8'd127, 8'd127, 1'b0, 1'b0, 2'b00, 2'b00, 32'h40000000, 4'b0001);
    idle();
    @(negedge clk);
    chk("post_rst_lat1", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    chk("post_rst_lat2", {31'b0, out_valid}, 32'd1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp32_mul_round.md
Name: fp32_mul_round

Overview:
- Downstream stage of the 24x24 mantissa multiplier in the single-precision FP multiply datapath.
- Takes the raw 48-bit mantissa product, both biased exponents, signs and operand classes.
- Normalises, rounds to nearest-even, detects overflow/underflow/special cases and packs an IEEE-754 binary32 result.
- Two-stage pipeline with valid/ready handshake on both sides.

Parameters:
- EXP_W, 8, biased exponent width.
- FRAC_W, 23, stored fraction width. The product width is 2*(FRAC_W+1).
- BIAS, 127, exponent bias.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept a beat
- in_prod  in  48  mantissa product, hidden bits included
- in_exp_a  in  8  biased exponent of operand A
- in_exp_b  in  8  biased exponent of operand B
- in_sign_a  in  1  sign of A
- in_sign_b  in  1  sign of B
- in_cls_a  in  2  class of A: 00 normal, 01 zero/denormal, 10 inf, 11 NaN
- in_cls_b  in  2  class of B, same encoding
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_result  out  32  packed binary32 result
- out_flags  out  4  {invalid, overflow, underflow, inexact}

Behaviour:
- Reset (async, rst=1): both stage valid bits = 0; out_valid = 0; out_result = 0; out_flags = 0; in_ready = 1 once rst deasserts. Reset mid-operation discards all in-flight beats.
- Handshake:
  - A transfer occurs when valid & ready on the same edge.
  - adv2 = !v2 | out_ready; adv1 = !v1 | adv2; in_ready = adv1 (combinational).
  - out_result and out_flags are held stable while out_valid & !out_ready.
  - No bubbles under continuous flow. Latency is exactly 2 cycles from acceptance to out_valid when out_ready = 1.
  - Beats leave in order. Simultaneous accept and drain is allowed.
- Stage 1 (normalise), registered on adv1:
  - sign = sign_a ^ sign_b.
  - e = exp_a + exp_b - BIAS, computed as a 10-bit signed value.
  - If prod[47] = 1: frac = prod[46:24], g = prod[23], st = |prod[22:0], e = e + 1.
  - Else: frac = prod[45:23], g = prod[22], st = |prod[21:0].
  - Special-case code is registered alongside.
- Stage 2 (round and pack), registered on adv2:
  - Round up when g & (st | frac[0]).
  - A fraction carry-out (frac all ones + 1) gives frac = 0 and e = e + 1.
  - inexact = g | st.
  - If e >= 255 after rounding: result = signed inf (exp 0xFF, frac 0); overflow = 1, inexact = 1.
  - If e <= 0 before rounding: result = signed zero (flush, no denormal output); underflow = 1, inexact = 1.
  - Otherwise: {sign, e[7:0], frac}.
- Special cases, in priority order; these override the arithmetic and clear overflow, underflow and inexact:
  - Either operand NaN: result 0x7FC00000, invalid = 0.
  - inf x zero (either order): result 0x7FC00000, invalid = 1.
  - Either operand inf: result {sign, 0xFF, 0}.
  - Either operand zero/denormal: result {sign, 31'b0}.
- in_prod is ignored whenever the operand classes select a special case.

Test Plan:
1. prod=0x900000000000, exps 127/127, signs 0/0, normal -> 2 cycles later 0x40100000, flags 0000.
2. prod=0x800001800000, exps 127/127 -> 0x40000002, flags 0001 (tie, odd lsb rounds up). prod=0x800000800000 -> 0x40000000, flags 0001 (tie, even lsb holds).
3. Exps 254/254, prod=0x400000000000 -> 0x7F800000, flags 0101. Exps 1/1, prod=0x400000000000, sign_a=1 -> 0x80000000, flags 0011.
4. cls_a=10, cls_b=01 -> 0x7FC00000, flags 1000. cls_a=11 -> 0x7FC00000, flags 0000. cls_a=10, cls_b=00, sign_b=1 -> 0xFF800000.
5. Backpressure: out_ready=0 while in_valid is held with 3 distinct beats -> exactly 2 beats accepted, then in_ready=0. out_result stays constant. When out_ready=1, results emerge in order one per cycle and the third beat is accepted the same cycle.
6. Assert rst for 1 cycle with 2 beats in flight -> out_valid=0, out_result=0 immediately (async). The next beat after release appears after 2 cycles.
